// File: rtl/periph_pkg.sv
// periph_pkg: shared types and constants for the peripheral APB subsystem.
package periph_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_demux_state_e;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } rule_t;

    localparam logic [31:0] PERIPH_BA_DEFAULT = 32'h0004_0000;
    localparam int EF_TCC32_REGS_QTY = 1024;
    localparam int RTC_REGS_QTY      = 16;

endpackage

// File: rtl/apb_demux_decoder.sv
// apb_demux_decoder: maps an address onto a slave window index; misaligned or out-of-map addresses miss.
module apb_demux_decoder
    import periph_pkg::*;
#(
    parameter int              AW           = 32,
    parameter int              SLAVES_QTY   = 2,
    parameter logic [AW-1:0]   PERIPH_BA    = PERIPH_BA_DEFAULT,
    parameter int              SLAVE_SPAN_W = 12,
    parameter int              IW           = 1
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    logic [AW-1:0] off;
    logic [AW-1:0] win;

    always_comb begin
        off = addr - PERIPH_BA;
        win = off >> SLAVE_SPAN_W;
        hit = (addr >= PERIPH_BA) && (win < AW'(SLAVES_QTY)) && (addr[1:0] == 2'b00);
        idx = win[IW-1:0];
    end

endmodule

// File: rtl/apb_periph_demux.sv
// apb_periph_demux: registered APB4 1-to-N demux with local error responses.
// Define APB_DEMUX_TIMEOUT_EN to answer hung slaves with PSLVERR after TIMEOUT_CYCLES.
module apb_periph_demux
    import periph_pkg::*;
#(
    parameter int            APB_AW         = 32,
    parameter int            APB_DW         = 32,
    parameter int            SLAVES_QTY     = 2,
    parameter logic [31:0]   PERIPH_BA      = PERIPH_BA_DEFAULT,
    parameter int            SLAVE_SPAN_W   = 12,
    parameter int            TIMEOUT_CYCLES = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [APB_AW-1:0]            s_paddr,
    input  logic [2:0]                   s_pprot,
    input  logic                         s_psel,
    input  logic                         s_penable,
    input  logic                         s_pwrite,
    input  logic [APB_DW-1:0]            s_pwdata,
    input  logic [APB_DW/8-1:0]          s_pstrb,
    output logic                         s_pready,
    output logic [APB_DW-1:0]            s_prdata,
    output logic                         s_pslverr,
    output logic [APB_AW-1:0]            m_paddr,
    output logic [2:0]                   m_pprot,
    output logic [SLAVES_QTY-1:0]        m_psel,
    output logic                         m_penable,
    output logic                         m_pwrite,
    output logic [APB_DW-1:0]            m_pwdata,
    output logic [APB_DW/8-1:0]          m_pstrb,
    input  logic [SLAVES_QTY-1:0]        m_pready,
    input  logic [SLAVES_QTY*APB_DW-1:0] m_prdata,
    input  logic [SLAVES_QTY-1:0]        m_pslverr
);

    localparam int IW = (SLAVES_QTY > 1) ? $clog2(SLAVES_QTY) : 1;

    if (APB_DW != 32) begin : g_dw_chk
        $error("APB_DW must be 32");
    end
    if (SLAVES_QTY < 1 || SLAVES_QTY > 16) begin : g_qty_chk
        $error("SLAVES_QTY must be within 1..16");
    end
    if ((PERIPH_BA & ((32'd1 << SLAVE_SPAN_W) - 32'd1)) != 32'd0) begin : g_ba_chk
        $error("PERIPH_BA must be aligned to the slave window size");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_to_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    apb_demux_state_e state;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    dec_idx;
    logic             dec_hit;

`ifdef APB_DEMUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`endif

    apb_demux_decoder #(
        .AW           (APB_AW),
        .SLAVES_QTY   (SLAVES_QTY),
        .PERIPH_BA    (APB_AW'(PERIPH_BA)),
        .SLAVE_SPAN_W (SLAVE_SPAN_W),
        .IW           (IW)
    ) u_decoder (
        .addr (s_paddr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            idx       <= '0;
            m_paddr   <= '0;
            m_pprot   <= '0;
            m_psel    <= '0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_pwdata  <= '0;
            m_pstrb   <= '0;
            s_pready  <= 1'b0;
            s_prdata  <= '0;
            s_pslverr <= 1'b0;
`ifdef APB_DEMUX_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (s_psel && !s_penable) begin
                        if (dec_hit) begin
                            // downstream bus is only touched for decoded hits
                            idx      <= dec_idx;
                            m_paddr  <= s_paddr;
                            m_pprot  <= s_pprot;
                            m_pwrite <= s_pwrite;
                            m_pwdata <= s_pwdata;
                            m_pstrb  <= s_pwrite ? s_pstrb : '0;
                            m_psel   <= SLAVES_QTY'(1) << dec_idx;
                            state    <= SETUP;
                        end else begin
                            s_pready  <= 1'b1;
                            s_pslverr <= 1'b1;
                            s_prdata  <= '0;
                            state     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    m_penable <= 1'b1;
                    state     <= ACCESS;
`ifdef APB_DEMUX_TIMEOUT_EN
                    cnt       <= '0;
`endif
                end
                ACCESS: begin
                    if (m_pready[idx]) begin
                        m_psel    <= '0;
                        m_penable <= 1'b0;
                        s_pready  <= 1'b1;
                        s_pslverr <= m_pslverr[idx];
                        s_prdata  <= (m_pwrite || m_pslverr[idx]) ? '0 : m_prdata[idx*APB_DW +: APB_DW];
                        state     <= RESP;
                    end
`ifdef APB_DEMUX_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        m_psel    <= '0;
                        m_penable <= 1'b0;
                        s_pready  <= 1'b1;
                        s_pslverr <= 1'b1;
                        s_prdata  <= '0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    s_pready  <= 1'b0;
                    s_pslverr <= 1'b0;
                    s_prdata  <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_periph_demux.sv
// tb_apb_periph_demux: directed vectors for apb_periph_demux (timeout case needs APB_DEMUX_TIMEOUT_EN).
module tb_apb_periph_demux;

`ifdef APB_DEMUX_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] s_paddr = '0;
    logic [2:0]  s_pprot = '0;
    logic        s_psel = 1'b0;
    logic        s_penable = 1'b0;
    logic        s_pwrite = 1'b0;
    logic [31:0] s_pwdata = '0;
    logic [3:0]  s_pstrb = '0;
    logic        s_pready;
    logic [31:0] s_prdata;
    logic        s_pslverr;
    logic [31:0] m_paddr;
    logic [2:0]  m_pprot;
    logic [1:0]  m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [31:0] m_pwdata;
    logic [3:0]  m_pstrb;
    logic [1:0]  m_pready = '0;
    logic [63:0] m_prdata = '0;
    logic [1:0]  m_pslverr = '0;

    int checks = 0;
    int errors = 0;

    apb_periph_demux #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .s_paddr   (s_paddr),
        .s_pprot   (s_pprot),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_pwrite  (s_pwrite),
        .s_pwdata  (s_pwdata),
        .s_pstrb   (s_pstrb),
        .s_pready  (s_pready),
        .s_prdata  (s_prdata),
        .s_pslverr (s_pslverr),
        .m_paddr   (m_paddr),
        .m_pprot   (m_pprot),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_pwdata  (m_pwdata),
        .m_pstrb   (m_pstrb),
        .m_pready  (m_pready),
        .m_prdata  (m_prdata),
        .m_pslverr (m_pslverr)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic setup(input logic [31:0] addr, input logic wr, input logic [31:0] wdata, input logic [3:0] strb);
        s_paddr   = addr;
        s_pwrite  = wr;
        s_pwdata  = wdata;
        s_pstrb   = strb;
        s_pprot   = 3'b010;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        tick();
        s_penable = 1'b1;
    endtask

    task automatic finish_up();
        s_psel    = 1'b0;
        s_penable = 1'b0;
        tick();
    endtask

    task automatic miss_case(input string tag, input logic [31:0] addr, input logic wr);
        setup(addr, wr, 32'h5555_AAAA, 4'hF);
        check({tag, "_pready"}, 32'(s_pready), 32'd1);
        check({tag, "_pslverr"}, 32'(s_pslverr), 32'd1);
        check({tag, "_prdata"}, s_prdata, 32'd0);
        check({tag, "_psel"}, 32'(m_psel), 32'd0);
        check({tag, "_penable"}, 32'(m_penable), 32'd0);
        finish_up();
        check({tag, "_pready_end"}, 32'(s_pready), 32'd0);
        check({tag, "_psel_end"}, 32'(m_psel), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_s_pready", 32'(s_pready), 32'd0);
        check("rst_s_prdata", s_prdata, 32'd0);
        check("rst_s_pslverr", 32'(s_pslverr), 32'd0);
        check("rst_m_psel", 32'(m_psel), 32'd0);
        check("rst_m_penable", 32'(m_penable), 32'd0);
        check("rst_m_paddr", m_paddr, 32'd0);
        check("rst_m_pstrb", 32'(m_pstrb), 32'd0);
        rst_ni = 1'b1;
        tick();

        // zero-wait write to slave 0
        m_pready = 2'b01;
        m_prdata = {32'h1234_5678, 32'hAAAA_AAAA};
        setup(32'h0004_0004, 1'b1, 32'hDEAD_BEEF, 4'hF);
        check("wr_T1_psel", 32'(m_psel), 32'h1);
        check("wr_T1_penable", 32'(m_penable), 32'd0);
        check("wr_T1_paddr", m_paddr, 32'h0004_0004);
        check("wr_T1_pwdata", m_pwdata, 32'hDEAD_BEEF);
        check("wr_T1_pstrb", 32'(m_pstrb), 32'hF);
        check("wr_T1_pwrite", 32'(m_pwrite), 32'd1);
        check("wr_T1_pprot", 32'(m_pprot), 32'h2);
        check("wr_T1_pready", 32'(s_pready), 32'd0);
        tick();
        check("wr_T2_psel", 32'(m_psel), 32'h1);
        check("wr_T2_penable", 32'(m_penable), 32'd1);
        check("wr_T2_pready", 32'(s_pready), 32'd0);
        tick();
        check("wr_T3_pready", 32'(s_pready), 32'd1);
        check("wr_T3_pslverr", 32'(s_pslverr), 32'd0);
        check("wr_T3_prdata", s_prdata, 32'd0);
        check("wr_T3_psel", 32'(m_psel), 32'd0);
        finish_up();
        check("wr_T4_pready", 32'(s_pready), 32'd0);

        // read slave 1 with 3 wait states; slave 0 ready must be ignored
        m_pready = 2'b01;
        setup(32'h0004_1008, 1'b0, 32'h0, 4'hF);
        check("rd_T1_psel", 32'(m_psel), 32'h2);
        check("rd_T1_pstrb", 32'(m_pstrb), 32'd0);
        tick();
        check("rd_T2_penable", 32'(m_penable), 32'd1);
        tick();
        tick();
        check("rd_T4_pready", 32'(s_pready), 32'd0);
        check("rd_T4_psel", 32'(m_psel), 32'h2);
        tick();
        check("rd_T5_pready", 32'(s_pready), 32'd0);
        m_pready = 2'b11;
        tick();
        m_pready = 2'b01;
        check("rd_T6_pready", 32'(s_pready), 32'd1);
        check("rd_T6_prdata", s_prdata, 32'h1234_5678);
        check("rd_T6_pslverr", 32'(s_pslverr), 32'd0);
        check("rd_T6_psel", 32'(m_psel), 32'd0);
        finish_up();
        check("rd_T7_prdata", s_prdata, 32'd0);

        // slave error on read: data suppressed
        m_pready  = 2'b10;
        m_pslverr = 2'b10;
        setup(32'h0004_1000, 1'b0, 32'h0, 4'h0);
        tick();
        tick();
        check("se_pready", 32'(s_pready), 32'd1);
        check("se_pslverr", 32'(s_pslverr), 32'd1);
        check("se_prdata", s_prdata, 32'd0);
        m_pslverr = 2'b00;
        finish_up();

        miss_case("miss_hi", 32'h0004_2000, 1'b0);
        miss_case("miss_lo", 32'h0003_FFFC, 1'b0);
        miss_case("misalign", 32'h0004_0002, 1'b1);

`ifdef APB_DEMUX_TIMEOUT_EN
        m_pready = 2'b00;
        setup(32'h0004_0000, 1'b0, 32'h0, 4'h0);
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("to_T9_psel", 32'(m_psel), 32'h1);
        check("to_T9_pready", 32'(s_pready), 32'd0);
        tick();
        check("to_T10_psel", 32'(m_psel), 32'd0);
        check("to_T10_penable", 32'(m_penable), 32'd0);
        check("to_T10_pready", 32'(s_pready), 32'd1);
        check("to_T10_pslverr", 32'(s_pslverr), 32'd1);
        finish_up();
`endif

        // reset during ACCESS, then a normal write
        m_pready = 2'b00;
        setup(32'h0004_0010, 1'b1, 32'hCAFE_0001, 4'h3);
        tick();
        check("ar_T2_penable", 32'(m_penable), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("ar_psel", 32'(m_psel), 32'd0);
        check("ar_penable", 32'(m_penable), 32'd0);
        check("ar_paddr", m_paddr, 32'd0);
        check("ar_pwdata", m_pwdata, 32'd0);
        check("ar_pready", 32'(s_pready), 32'd0);
        s_psel    = 1'b0;
        s_penable = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        m_pready = 2'b01;
        setup(32'h0004_0020, 1'b1, 32'h0BAD_F00D, 4'h5);
        check("pr_T1_psel", 32'(m_psel), 32'h1);
        check("pr_T1_pstrb", 32'(m_pstrb), 32'h5);
        tick();
        tick();
        check("pr_T3_pready", 32'(s_pready), 32'd1);
        check("pr_T3_pslverr", 32'(s_pslverr), 32'd0);
        check("pr_T3_pwdata", m_pwdata, 32'h0BAD_F00D);
        finish_up();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
